// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions and issues the head to the
// reservation station named by its FU field when that station and the ROB have room.
module dispatch_queue #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_FU    = 4,
  parameter int FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [FU_W-1:0]            in_fu,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  output logic                       in_ready,
  input  logic [NUM_FU-1:0]          rs_is_full,
  input  logic                       rob_full,
  output logic                       out_valid,
  output logic [FU_W-1:0]            out_fu,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [NUM_FU-1:0]          rs_load,
  output logic                       rob_alloc,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int FU_SPAN = 1 << FU_W;
  localparam logic [FU_W:0]  NUM_FU_L = (FU_W + 1)'(NUM_FU);
  localparam logic [CNT_W-1:0] FULL_L = CNT_W'(DEPTH);

  // Handshake: an entry is taken on a rising edge only when in_valid and in_ready are
  // both high; in_ready depends on registered occupancy and flush, never on in_valid.
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [FU_W-1:0]      fu_mem [DEPTH];
  logic [PAYLOAD_W-1:0] pl_mem [DEPTH];
  logic [FU_SPAN-1:0]   rs_full_pad;
  logic                 head_valid, active, legal, blocked;
  logic                 enq, deq, fire, drop;

  assign head_valid  = (count_q != '0);
  assign in_ready    = (count_q != FULL_L) & ~flush;
  assign enq         = in_valid & in_ready;
  assign out_valid   = head_valid;
  assign out_fu      = fu_mem[head_q];
  assign out_payload = pl_mem[head_q];
  assign count       = count_q;

  // Selector codes beyond NUM_FU read a padded zero rather than an out-of-range bit.
  always_comb begin
    rs_full_pad = '0;
    rs_full_pad[NUM_FU-1:0] = rs_is_full;
  end

  assign legal     = ({1'b0, out_fu} < NUM_FU_L);
  assign blocked   = rs_full_pad[out_fu] | rob_full;
  assign active    = head_valid & ~flush;
  assign fire      = active & legal & ~blocked;
  assign drop      = active & ~legal;
  assign deq       = fire | drop;
  assign stall     = active & legal & blocked;
  assign rob_alloc = fire;

  always_comb begin
    rs_load = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      rs_load[i] = fire & (out_fu == FU_W'(i));
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = head_q + PTR_W'(1);
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (enq && !deq)      count_d = count_q + CNT_W'(1);
      else if (!enq && deq) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      fu_mem[tail_q] <= in_fu;
      pl_mem[tail_q] <= in_payload;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios plus randomized traffic against a
// queue-based reference; a second instance built with NUM_FU = 3 covers the drop path.
`timescale 1ns/1ps
module tb_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int PW    = 64;
  localparam int NFU   = 4;
  localparam int FW    = 2;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (default build) ----------------
  logic          flush = 1'b0, in_valid = 1'b0, rob_full = 1'b0;
  logic [FW-1:0] in_fu = '0;
  logic [PW-1:0] in_payload = '0;
  logic [NFU-1:0] rs_is_full = '0;
  logic          in_ready, out_valid, rob_alloc, stall;
  logic [FW-1:0] out_fu;
  logic [PW-1:0] out_payload;
  logic [NFU-1:0] rs_load;
  logic [CW-1:0] count;

  dispatch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .NUM_FU(NFU)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_fu(in_fu), .in_payload(in_payload), .in_ready(in_ready),
    .rs_is_full(rs_is_full), .rob_full(rob_full), .out_valid(out_valid),
    .out_fu(out_fu), .out_payload(out_payload), .rs_load(rs_load),
    .rob_alloc(rob_alloc), .stall(stall), .count(count)
  );

  // ---------------- instance B (NUM_FU = 3) ----------------
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_rob_full = 1'b0;
  logic [1:0]  b_in_fu = '0;
  logic [15:0] b_in_payload = '0;
  logic [2:0]  b_rs_is_full = '0;
  logic        b_in_ready, b_out_valid, b_rob_alloc, b_stall;
  logic [1:0]  b_out_fu;
  logic [15:0] b_out_payload;
  logic [2:0]  b_rs_load;
  logic [2:0]  b_count;

  dispatch_queue #(.DEPTH(4), .PAYLOAD_W(16), .NUM_FU(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid),
    .in_fu(b_in_fu), .in_payload(b_in_payload), .in_ready(b_in_ready),
    .rs_is_full(b_rs_is_full), .rob_full(b_rob_full), .out_valid(b_out_valid),
    .out_fu(b_out_fu), .out_payload(b_out_payload), .rs_load(b_rs_load),
    .rob_alloc(b_rob_alloc), .stall(b_stall), .count(b_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [FW+PW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge reset_n) exp_q.delete();

  // Reference: the queue contents are the list of accepted-but-not-dispatched entries.
  logic          m_hv, m_fire;
  logic [FW-1:0] m_fu;
  always @(negedge clk) begin
    if (reset_n) begin
      m_hv   = (exp_q.size() != 0);
      m_fu   = m_hv ? exp_q[0][FW+PW-1:PW] : '0;
      m_fire = m_hv && !flush && !rs_is_full[m_fu] && !rob_full;
      chk("m_count", 64'(count), 64'(exp_q.size()));
      chk("m_out_valid", 64'(out_valid), 64'(m_hv));
      chk("m_in_ready", 64'(in_ready), 64'((exp_q.size() < DEPTH) && !flush));
      chk("m_rs_load", 64'(rs_load), m_fire ? (64'd1 << m_fu) : 64'd0);
      chk("m_rob_alloc", 64'(rob_alloc), 64'(m_fire));
      chk("m_stall", 64'(stall), 64'(m_hv && !flush && !m_fire));
      if (m_hv) begin
        chk("m_out_fu", 64'(out_fu), 64'(m_fu));
        chk("m_out_payload", out_payload, exp_q[0][PW-1:0]);
      end
      if (flush) exp_q.delete();
      else begin
        if (m_fire) void'(exp_q.pop_front());
        if (in_valid && exp_q.size() + (m_fire ? 1 : 0) < DEPTH)
          exp_q.push_back({in_fu, in_payload});
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] rnd_pl();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive_a(input logic v, input logic [FW-1:0] fu, input logic [PW-1:0] pl,
                         input logic [NFU-1:0] rsf, input logic robf, input logic fl);
    in_valid = v; in_fu = fu; in_payload = pl; rs_is_full = rsf; rob_full = robf; flush = fl;
  endtask

  task automatic to_next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rs_load", 64'(rs_load), 64'd0);
    chk("rst_rob_alloc", 64'(rob_alloc), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0);
    while (count != '0 && n < budget) begin
      to_next();
      n++;
    end
    chk("drain_empty", 64'(count), 64'd0);
  endtask

  // Backpressure pair fu=1 then fu=3 held by either an RS-full or a ROB-full source.
  task automatic backpressure(input logic [NFU-1:0] rsf, input logic robf);
    logic [PW-1:0] p1, p3;
    p1 = rnd_pl(); p3 = rnd_pl();
    drive_a(1'b1, 2'd1, p1, rsf, robf, 1'b0);
    to_next();
    drive_a(1'b1, 2'd3, p3, rsf, robf, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall", 64'(stall), 64'd1);
      chk("bp_rs_load", 64'(rs_load), 64'd0);
      to_next();
      in_valid = 1'b0;
    end
    drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_rel_first", 64'(rs_load), 64'b0010);
    chk("bp_rel_first_pl", out_payload, p1);
    to_next();
    @(negedge clk);
    chk("bp_rel_second", 64'(rs_load), 64'b1000);
    chk("bp_rel_second_pl", out_payload, p3);
    to_next();
    @(negedge clk);
    chk("bp_empty", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] pl;
    logic [FW-1:0] f0;
    int in_pct, rsf_pct;

    @(negedge clk);
    chk("init_count", 64'(count), 64'd0);
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_rs_load", 64'(rs_load), 64'd0);
    chk("init_stall", 64'(stall), 64'd0);
    chk("init_b_count", 64'(b_count), 64'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    chk("init_in_ready", 64'(in_ready), 64'd1);

    // basic dispatch: fu=3 enqueued, dispatched next cycle
    pl = rnd_pl();
    drive_a(1'b1, 2'd3, pl, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_c1_count", 64'(count), 64'd0);
    to_next();
    drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_out_valid", 64'(out_valid), 64'd1);
    chk("basic_rs_load", 64'(rs_load), 64'b1000);
    chk("basic_rob_alloc", 64'(rob_alloc), 64'd1);
    chk("basic_payload", out_payload, pl);
    to_next();
    @(negedge clk);
    chk("basic_c3_count", 64'(count), 64'd0);
    to_next();

    backpressure(4'b0010, 1'b0);
    to_next();
    backpressure(4'b0000, 1'b1);
    to_next();

    // full and wrap
    f0 = 2'($urandom_range(0, 3));
    for (int k = 0; k < DEPTH; k++) begin
      drive_a(1'b1, (k == 0) ? f0 : 2'($urandom_range(0, 3)), rnd_pl(), 4'b1111, 1'b0, 1'b0);
      to_next();
    end
    drive_a(1'b1, 2'($urandom_range(0, 3)), rnd_pl(), 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_rs_load", 64'(rs_load), 64'd1 << f0);
    to_next();
    for (int k = 0; k < 20; k++) begin
      drive_a(1'b1, 2'($urandom_range(0, 3)), rnd_pl(), 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      if (k == 0) chk("full_refused_count", 64'(count), 64'd7);
      chk("stream_le_depth", 64'(count <= CW'(DEPTH)), 64'd1);
      to_next();
    end
    wait_empty(40);

    // flush with 5 queued, head dispatchable, incoming valid
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 2'($urandom_range(0, 3)), rnd_pl(), 4'b1111, 1'b0, 1'b0);
      to_next();
    end
    drive_a(1'b1, 2'd0, rnd_pl(), 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_count_before", 64'(count), 64'd5);
    chk("flush_rs_load", 64'(rs_load), 64'd0);
    chk("flush_rob_alloc", 64'(rob_alloc), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    to_next();
    drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count_after", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    to_next();

    // asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, 2'($urandom_range(0, 3)), rnd_pl(), 4'b1111, 1'b0, 1'b0);
      to_next();
    end
    do_reset();

    // NUM_FU = 3 build: illegal fu=3 drops, fu=0 then dispatches
    b_in_valid = 1'b1; b_in_fu = 2'd3; b_in_payload = 16'h1111;
    to_next();
    b_in_fu = 2'd0; b_in_payload = 16'h2222;
    @(negedge clk);
    chk("b_drop_valid", 64'(b_out_valid), 64'd1);
    chk("b_drop_rs_load", 64'(b_rs_load), 64'd0);
    chk("b_drop_rob_alloc", 64'(b_rob_alloc), 64'd0);
    chk("b_drop_stall", 64'(b_stall), 64'd0);
    to_next();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_next_rs_load", 64'(b_rs_load), 64'b001);
    chk("b_next_payload", 64'(b_out_payload), 64'h2222);
    chk("b_next_count", 64'(b_count), 64'd1);
    to_next();
    @(negedge clk);
    chk("b_final_count", 64'(b_count), 64'd0);
    to_next();

    // randomized traffic
    in_pct = 70; rsf_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        in_pct  = $urandom_range(20, 100);
        rsf_pct = $urandom_range(0, 80);
      end
      in_valid   = ($urandom_range(0, 99) < in_pct);
      in_fu      = 2'($urandom_range(0, 3));
      in_payload = rnd_pl();
      for (int b = 0; b < NFU; b++) rs_is_full[b] = ($urandom_range(0, 99) < rsf_pct);
      rob_full   = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      to_next();
    end
    wait_empty(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
